ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, RAM data width.
REQ-002 Parameter ADDRESS_WIDTH, default 16, RAM address width.
REQ-003 Parameter NUM_REQ, default 3, requester count (0 solver, 1 interpolation, 2 host loader).
REQ-004 Parameter LOCK_MAX, default 8, max consecutive locked grants per owner.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  NUM_REQ  per-requester access request, held until granted.
REQ-008 lock  input  NUM_REQ  per-requester burst-hold request.
REQ-009 we  input  NUM_REQ  per-requester write (1) / read (0).
REQ-010 addr  input  NUM_REQ*ADDRESS_WIDTH  flattened addresses, requester i at slice i.
REQ-011 wdata  input  NUM_REQ*WORD_SIZE  flattened write data, requester i at slice i.
REQ-012 gnt  output  NUM_REQ  registered one-hot grant; access performed in the gnt cycle.
REQ-013 rvalid  output  NUM_REQ  read data valid for requester i.
REQ-014 rdata  output  WORD_SIZE  read data, valid when any rvalid is high.
REQ-015 ram_add  output  ADDRESS_WIDTH  RAM address.
REQ-016 ram_wdata  output  WORD_SIZE  RAM write data.
REQ-017 ram_rdata  input  WORD_SIZE  RAM read data, one-cycle synchronous latency.
REQ-018 ram_en  output  1  RAM access enable.
REQ-019 mem_write  output  1  RAM write strobe.

Function
REQ-020 gnt for cycle t+1 is computed at edge t from req/lock/we values present in cycle t; at most one gnt bit is high.
REQ-021 Round-robin: owner = first i with req[i]=1 scanning from ptr upward modulo NUM_REQ; ptr becomes owner+1 mod NUM_REQ on every non-locked grant.
REQ-022 No req bit high: gnt=0, ram_en=0, mem_write=0, ram_add=0, ram_wdata=0, ptr unchanged.
REQ-023 During gnt[i] cycle: ram_en=1, ram_add=addr[i], ram_wdata=wdata[i], mem_write=we[i].
REQ-024 Read granted in cycle t: rvalid[i]=1 in cycle t+1 with rdata=ram_rdata; writes never assert rvalid.
REQ-025 Requester done after one access deasserts req in its gnt cycle; req held high requests another access.
REQ-026 Lock: if gnt[i], req[i] and lock[i] all high in cycle t and lock count < LOCK_MAX-1, gnt[i] repeats in t+1 regardless of other requests; ptr unchanged.
REQ-027 Lock counter increments per locked repeat, clears on owner change or idle; at LOCK_MAX consecutive grants normal round-robin is forced (ptr = owner+1).
REQ-028 Throughput: one access per cycle, back-to-back grants allowed across different owners with no bubble.
REQ-029 gnt never asserted for a requester whose req was low in the decision cycle.
REQ-030 Simultaneous requests from all requesters with ptr=0: grant order 0,1,2,0,... while held.

Reset
REQ-031 rst high at edge: gnt=0, rvalid=0, ptr=0, lock counter=0, ram_en=0, mem_write=0, ram_add=0.
REQ-032 Reset during a read grant suppresses the pending rvalid; first grant after reset is at earliest one cycle after rst deasserts.

Structure
REQ-033 Shared package holds WORD_SIZE, ADDRESS_WIDTH, NUM_REQ, LOCK_MAX and requester index constants REQ_SOLVER=0, REQ_INTERP=1, REQ_HOST=2.
REQ-034 One combinational sub-module rr_priority_picker (req vector, ptr -> one-hot winner, valid) is instantiated once.

Verification
REQ-035 Single read: req[1]=1, we=0, addr=0x000A in cycle 0 -> gnt=3'b010 in cycle 1, ram_add=0x000A, rvalid[1]=1 with rdata=ram_rdata in cycle 2.
REQ-036 Contention: req=3'b111 held from cycle 0, ptr=0 -> gnt 001,010,100,001 in cycles 1-4, ram_en=1 continuously.
REQ-037 Write: req[2]=1, we[2]=1, addr=0x0004, wdata=0x1234 -> mem_write=1, ram_wdata=0x1234 in gnt cycle, no rvalid.
REQ-038 Lock limit: req=3'b011, lock[0]=1 held -> gnt[0] for exactly 8 cycles, then gnt[1] for one cycle.
REQ-039 Reset mid-read: rst=1 in cycle after read grant -> rvalid stays 0, all outputs 0, next grant ordered from ptr=0.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared sizes and requester indices (0 solver, 1 interpolation, 2 host loader)
package ram_port_arbiter_pkg;
  localparam int WORD_SIZE = 16;
  localparam int ADDRESS_WIDTH = 16;
  localparam int NUM_REQ = 3;
  localparam int LOCK_MAX = 8;
  localparam int REQ_SOLVER = 0;
  localparam int REQ_INTERP = 1;
  localparam int REQ_HOST = 2;
endpackage

// File: rtl/ram_port_arbiter_picker.sv
// rr_priority_picker: first set req bit scanning up from ptr (mod N) -> one-hot win, its index, valid
module rr_priority_picker
  import ram_port_arbiter_pkg::*;
#(
  parameter int N = NUM_REQ,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          valid
);
  logic [PW-1:0] j;
  always_comb begin
    win = '0;
    win_idx = '0;
    valid = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (!valid && req[j]) begin
        valid = 1'b1;
        win_idx = j;
        win[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin RAM port arbiter with bounded lock; req/lock/we/addr/wdata in, gnt/rvalid/rdata and RAM port out
module ram_port_arbiter #(
  parameter int WORD_SIZE = ram_port_arbiter_pkg::WORD_SIZE,
  parameter int ADDRESS_WIDTH = ram_port_arbiter_pkg::ADDRESS_WIDTH,
  parameter int NUM_REQ = ram_port_arbiter_pkg::NUM_REQ,
  parameter int LOCK_MAX = ram_port_arbiter_pkg::LOCK_MAX
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 lock,
  input  logic [NUM_REQ-1:0]                 we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0]       wdata,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [NUM_REQ-1:0]                 rvalid,
  output logic [WORD_SIZE-1:0]               rdata,
  output logic [ADDRESS_WIDTH-1:0]           ram_add,
  output logic [WORD_SIZE-1:0]               ram_wdata,
  input  logic [WORD_SIZE-1:0]               ram_rdata,
  output logic                               ram_en,
  output logic                               mem_write
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win_idx;
  logic [CW-1:0] lock_cnt;
  logic [NUM_REQ-1:0] win;
  logic valid;
  logic hold;
  rr_priority_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req(req),
    .ptr(ptr),
    .win(win),
    .win_idx(win_idx),
    .valid(valid)
  );
  // current owner keeps the port while it holds req+lock, capped at LOCK_MAX grants in a row
  assign hold = ram_en && req[owner] && lock[owner] && (lock_cnt < CW'(LOCK_MAX - 1));
  assign ram_en = |gnt;
  assign mem_write = ram_en && we[owner];
  assign ram_add = ram_en ? addr[owner*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
  assign ram_wdata = ram_en ? wdata[owner*WORD_SIZE +: WORD_SIZE] : '0;
  assign rdata = ram_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt <= '0;
      rvalid <= '0;
      owner <= '0;
      ptr <= '0;
      lock_cnt <= '0;
    end else begin
      rvalid <= gnt & ~we;
      if (hold) begin
        lock_cnt <= lock_cnt + 1'b1;
      end else begin
        gnt <= win;
        lock_cnt <= '0;
        if (valid) begin
          owner <= win_idx;
          ptr <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus, spec-level arbitration model compared every cycle, plus literal pins
module tb_ram_port_arbiter;
  localparam int N = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LM = 8;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_add;
  logic ram_en, mem_write;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] ram [256];
  logic [DW-1:0] mm [256];
  int m_owner = -1;
  int m_ptr = 0;
  int m_run = 0;
  int m_rv = -1;
  int m_nxt;
  int jj;
  logic [DW-1:0] m_rd;
  logic [AW-1:0] ta;
  logic [N-1:0] eg, erv;
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_add(ram_add), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_en(ram_en), .mem_write(mem_write)
  );

  // environment RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_en && mem_write) ram[ram_add[7:0]] <= ram_wdata;
    if (ram_en && !mem_write) ram_rdata <= ram[ram_add[7:0]];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // model: who owns the port next, stated directly from the arbitration rules
  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_ptr = 0;
      m_run = 0;
      m_rv = -1;
    end else begin
      m_rv = -1;
      if (m_owner >= 0) begin
        ta = addr[m_owner*AW +: AW];
        if (we[m_owner]) mm[ta[7:0]] = wdata[m_owner*DW +: DW];
        else begin
          m_rv = m_owner;
          m_rd = mm[ta[7:0]];
        end
      end
      if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_run < LM) m_run++;
      else begin
        m_nxt = -1;
        for (int k = 0; k < N; k++) begin
          jj = (m_ptr + k) % N;
          if (m_nxt < 0 && req[jj]) m_nxt = jj;
        end
        m_owner = m_nxt;
        if (m_nxt >= 0) begin
          m_ptr = (m_nxt + 1) % N;
          m_run = 1;
        end else m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    erv = (m_rv >= 0) ? (N'(1) << m_rv) : '0;
    ea = (m_owner >= 0) ? addr[m_owner*AW +: AW] : '0;
    ed = (m_owner >= 0) ? wdata[m_owner*DW +: DW] : '0;
    chk("m_gnt", 32'(gnt), 32'(eg));
    chk("m_ram_en", 32'(ram_en), 32'(m_owner >= 0));
    chk("m_mem_write", 32'(mem_write), 32'(m_owner >= 0 && we[m_owner]));
    chk("m_ram_add", 32'(ram_add), 32'(ea));
    chk("m_ram_wdata", 32'(ram_wdata), 32'(ed));
    chk("m_rvalid", 32'(rvalid), 32'(erv));
    if (m_rv >= 0) chk("m_rdata", 32'(rdata), 32'(m_rd));
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset;
    req = '0;
    lock = '0;
    we = '0;
    rst = 1'b1;
    nxt;
    rst = 1'b0;
  endtask

  logic [N-1:0] seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [3*N-1:0] vec [16] = '{
    9'b011_000_000, 9'b000_000_000, 9'b111_000_101, 9'b110_000_010,
    9'b101_100_000, 9'b101_100_000, 9'b101_100_000, 9'b001_000_001,
    9'b010_010_000, 9'b010_010_000, 9'b111_111_000, 9'b111_111_111,
    9'b100_000_100, 9'b000_000_000, 9'b011_001_010, 9'b111_000_000
  };

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'hA000 + 16'(i);
      mm[i] = 16'hA000 + 16'(i);
    end
    rst = 1'b1;
    req = '0;
    lock = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_rvalid", 32'(rvalid), 0);
    chk("reset_ram_add", 32'(ram_add), 0);
    nxt;
    // single read from requester 1
    set_a(1, 16'h000A, 16'h0);
    req = 3'b010;
    @(negedge clk);
    chk("rd_no_gnt_yet", 32'(gnt), 0);
    nxt;
    req = 3'b000;
    @(negedge clk);
    chk("rd_gnt", 32'(gnt), 32'h2);
    chk("rd_add", 32'(ram_add), 32'h000A);
    nxt;
    @(negedge clk);
    chk("rd_rvalid", 32'(rvalid), 32'h2);
    chk("rd_data", 32'(rdata), 32'hA00A);
    // write from requester 2, then read it back
    nxt;
    set_a(2, 16'h0004, 16'h1234);
    req = 3'b100;
    we = 3'b100;
    nxt;
    req = 3'b000;
    @(negedge clk);
    chk("wr_gnt", 32'(gnt), 32'h4);
    chk("wr_mem_write", 32'(mem_write), 1);
    chk("wr_wdata", 32'(ram_wdata), 32'h1234);
    nxt;
    we = 3'b000;
    @(negedge clk);
    chk("wr_no_rvalid", 32'(rvalid), 0);
    req = 3'b100;
    nxt;
    req = 3'b000;
    nxt;
    @(negedge clk);
    chk("wr_readback", 32'(rdata), 32'h1234);
    // three-way contention from ptr=0
    nxt;
    do_reset;
    for (int i = 0; i < N; i++) set_a(i, 16'(16 + i), 16'(i));
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      nxt;
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(seq[k]));
      chk("rr_ram_en", 32'(ram_en), 1);
    end
    nxt;
    req = 3'b000;
    nxt;
    // lock limit: 8 grants to requester 0, then one to requester 1
    do_reset;
    req = 3'b011;
    lock = 3'b001;
    for (int k = 1; k <= 9; k++) begin
      nxt;
      @(negedge clk);
      chk("lock_gnt", 32'(gnt), (k <= LM) ? 32'h1 : 32'h2);
    end
    nxt;
    req = 3'b000;
    lock = 3'b000;
    nxt;
    nxt;
    // reset during a read grant
    req = 3'b010;
    nxt;
    req = 3'b000;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_gnt", 32'(gnt), 32'h2);
    nxt;
    rst = 1'b0;
    req = 3'b111;
    @(negedge clk);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_ram_add", 32'(ram_add), 0);
    nxt;
    req = 3'b000;
    @(negedge clk);
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    nxt;
    // directed mixed traffic, checked by the model
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < N; i++) set_a(i, 16'(v * 3 + i + 32), 16'(v * 7 + i + 16'h0500));
      {req, lock, we} = vec[v];
      nxt;
    end
    req = '0;
    lock = '0;
    we = '0;
    repeat (3) nxt;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
